adc_frame_aligner: RTL and testbench
====================================

ADC_FRAME_ALIGNER -- requirements
Module: adc_frame_aligner

Interface
REQ-001 Parameter WIDTH, 12, bits per deserialized ADC word.
REQ-002 Parameter FRAME_PATTERN, 12'hFC0, expected deserialized frame-clock word when aligned.
REQ-003 Parameter SLIP_WAIT, 4, cycles to wait after each bitslip before checking.
REQ-004 Parameter LOCK_COUNT, 16, consecutive matching frame words required to declare lock.
REQ-005 Parameter LOSS_COUNT, 4, consecutive mismatching frame words that drop lock.
REQ-006 clk  input  1  word clock; all logic single clock domain, rising edge.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  alignment enable; low forces IDLE.
REQ-009 frame_word  input  WIDTH  raw deserialized frame-clock word, one per clk.
REQ-010 data_word  input  WIDTH  raw deserialized ADC data word, same lane timing as frame_word.
REQ-011 bitslip  output  1  single-cycle bitslip request to deserializers.
REQ-012 data_out  output  WIDTH  aligned ADC sample.
REQ-013 data_valid  output  1  data_out valid this cycle.
REQ-014 locked  output  1  alignment achieved.
REQ-015 slip_count  output  4  bitslips issued in current search.
REQ-016 align_error  output  1  sticky: WIDTH slips exhausted without lock.

Function
REQ-017 States SHALL be IDLE, CHECK, SLIP, WAIT, LOCKED.
REQ-018 IDLE: enable high -> CHECK next cycle; slip_count and match counter cleared.
REQ-019 CHECK: frame_word == FRAME_PATTERN increments match counter; counter reaching LOCK_COUNT -> LOCKED.
REQ-020 CHECK: any mismatch clears match counter and -> SLIP.
REQ-021 SLIP: bitslip high exactly one cycle, slip_count += 1, -> WAIT.
REQ-022 WAIT: frame_word ignored for SLIP_WAIT cycles, then -> CHECK.
REQ-023 When slip_count reaches WIDTH and a further mismatch occurs, align_error SHALL set, slip_count wraps to 0, search continues (no extra bitslip that cycle beyond the normal SLIP).
REQ-024 align_error SHALL clear only on reset or enable low.
REQ-025 LOCKED: locked high; data_out registered from data_word, data_valid high, latency 1 clk.
REQ-026 LOCKED: LOSS_COUNT consecutive mismatches -> CHECK with locked low, match counter cleared, slip_count kept; a single match resets the loss counter.
REQ-027 data_valid SHALL be low in every state except LOCKED; data_out holds last value when invalid.
REQ-028 enable low in any state -> IDLE next cycle; bitslip never asserted in that cycle.
REQ-029 bitslip SHALL never assert in two consecutive cycles; minimum spacing SLIP_WAIT+2 cycles.
REQ-030 Counters SHALL saturate-free widths: match/loss counters ceil(log2(LOCK_COUNT+1)) bits; no wrap before threshold.

Reset
REQ-031 rstn low: state IDLE, bitslip 0, data_out 0, data_valid 0, locked 0, slip_count 0, align_error 0, all counters 0.
REQ-032 Reset asserted mid-search or mid-lock SHALL take effect asynchronously; release synchronous to clk, first active state change no earlier than first clk edge after release.

Structure
REQ-033 Shared package holds state enumeration, FRAME_PATTERN default and WIDTH default for reuse by all ADC lane receivers.
REQ-034 One sub-module natural: adc_frame_match_cnt (compare + consecutive match/loss counter), instantiated once.

Verification
REQ-035 Frame pre-aligned (12'hFC0 from cycle 0), enable high -> no bitslip, locked high after 1+16 checks, data_out = data_word delayed 1 clk.
REQ-036 Frame rotated by 3 bits, model rotates on each bitslip -> exactly 3 bitslip pulses spaced >=6 cycles, slip_count=3, then locked.
REQ-037 Frame constant 12'h555 -> align_error sets after 12 slips plus mismatch, slip_count wraps to 0, locked stays 0.
REQ-038 Locked, inject 3 mismatches then match -> stays locked; inject 4 consecutive -> locked low, data_valid low next cycle.
REQ-039 rstn low during WAIT -> all outputs 0 immediately; after release, restart from IDLE.
REQ-040 enable dropped while LOCKED -> IDLE, locked and data_valid low next cycle, align_error cleared.

Source files
------------

// File: rtl/adc_frame_aligner_pkg.sv
// Shared definitions for ADC lane receivers: alignment state encoding,
// default word width and frame pattern, and a counter sizing helper.
package adc_frame_aligner_pkg;

    localparam int ADC_WIDTH = 12;
    localparam logic [ADC_WIDTH-1:0] ADC_FRAME_PATTERN = 12'hFC0;
    localparam int SLIP_COUNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED
    } align_state_t;

    // Bits needed to hold the value max_value without wrapping.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/adc_frame_aligner_if.sv
// Lane-side and status signals of one ADC frame aligner. The master side
// owns the deserialized words and the enable; the slave is the aligner.
interface adc_frame_aligner_if
    import adc_frame_aligner_pkg::*;
#(
    parameter int WIDTH = ADC_WIDTH
);

    logic                    enable;
    logic [WIDTH-1:0]        frame_word;
    logic [WIDTH-1:0]        data_word;
    logic                    bitslip;
    logic [WIDTH-1:0]        data_out;
    logic                    data_valid;
    logic                    locked;
    logic [SLIP_COUNT_W-1:0] slip_count;
    logic                    align_error;

    modport master (
        output enable, frame_word, data_word,
        input  bitslip, data_out, data_valid, locked, slip_count, align_error
    );

    modport slave (
        input  enable, frame_word, data_word,
        output bitslip, data_out, data_valid, locked, slip_count, align_error
    );

endinterface

// File: rtl/adc_frame_match_cnt.sv
// Frame word comparator with consecutive-match and consecutive-loss counters.
// The match counter runs while searching, the loss counter while locked; both
// sit at zero otherwise so every new search or lock starts from a clean count.
module adc_frame_match_cnt
    import adc_frame_aligner_pkg::*;
#(
    parameter int               WIDTH         = ADC_WIDTH,
    parameter logic [WIDTH-1:0] FRAME_PATTERN = ADC_FRAME_PATTERN,
    parameter int               LOCK_COUNT    = 16,
    parameter int               LOSS_COUNT    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             check_en,
    input  logic             monitor_en,
    input  logic [WIDTH-1:0] frame_word,
    output logic             frame_match,
    output logic             lock_reached,
    output logic             loss_reached
);

    localparam int CNT_W = cnt_width((LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT);

    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] loss_cnt;

    assign frame_match  = (frame_word == FRAME_PATTERN);
    assign lock_reached = check_en && frame_match && (match_cnt == CNT_W'(LOCK_COUNT - 1));
    assign loss_reached = monitor_en && !frame_match && (loss_cnt == CNT_W'(LOSS_COUNT - 1));

    // Count consecutive matching words during the search; any miss restarts it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            match_cnt <= '0;
        end else if (clear || !check_en || !frame_match) begin
            match_cnt <= '0;
        end else begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    // Count consecutive missing words while locked; a single good word forgives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            loss_cnt <= '0;
        end else if (clear || !monitor_en || frame_match || loss_reached) begin
            loss_cnt <= '0;
        end else begin
            loss_cnt <= loss_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_frame_aligner.sv
// ADC frame aligner: issues bitslips to the lane deserializers until the frame
// clock word shows the expected pattern for LOCK_COUNT words in a row, then
// passes data words through with one cycle of latency while monitoring lock.
// slip_count is 4 bits wide, so WIDTH must not exceed 15.
module adc_frame_aligner
    import adc_frame_aligner_pkg::*;
#(
    parameter int               WIDTH         = ADC_WIDTH,
    parameter logic [WIDTH-1:0] FRAME_PATTERN = ADC_FRAME_PATTERN,
    parameter int               SLIP_WAIT     = 4,
    parameter int               LOCK_COUNT    = 16,
    parameter int               LOSS_COUNT    = 4
) (
    input  logic                clk,
    input  logic                rstn,
    adc_frame_aligner_if.slave  bus
);

    localparam int WAIT_W = cnt_width(SLIP_WAIT);

    align_state_t            state;
    align_state_t            state_next;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [SLIP_COUNT_W-1:0] slip_count;
    logic                    align_error;
    logic [WIDTH-1:0]        data_out_q;
    logic                    data_valid_q;
    logic                    frame_match;
    logic                    lock_reached;
    logic                    loss_reached;

    adc_frame_match_cnt #(
        .WIDTH         (WIDTH),
        .FRAME_PATTERN (FRAME_PATTERN),
        .LOCK_COUNT    (LOCK_COUNT),
        .LOSS_COUNT    (LOSS_COUNT)
    ) u_match_cnt (
        .clk          (clk),
        .rstn         (rstn),
        .clear        (!bus.enable),
        .check_en     (state == ST_CHECK),
        .monitor_en   (state == ST_LOCKED),
        .frame_word   (bus.frame_word),
        .frame_match  (frame_match),
        .lock_reached (lock_reached),
        .loss_reached (loss_reached)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE.
    always_comb begin
        state_next = state;
        if (!bus.enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_next = ST_CHECK;
                ST_CHECK: begin
                    if (!frame_match) begin
                        state_next = ST_SLIP;
                    end else if (lock_reached) begin
                        state_next = ST_LOCKED;
                    end
                end
                ST_SLIP:   state_next = ST_WAIT;
                ST_WAIT: begin
                    if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                        state_next = ST_CHECK;
                    end
                end
                ST_LOCKED: begin
                    if (loss_reached) begin
                        state_next = ST_CHECK;
                    end
                end
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Settling time after each bitslip, counted while in WAIT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Slip bookkeeping; exhausting all bit positions flags a sticky error and restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slip_count  <= '0;
            align_error <= 1'b0;
        end else if (!bus.enable) begin
            slip_count  <= '0;
            align_error <= 1'b0;
        end else if (state == ST_IDLE) begin
            slip_count <= '0;
        end else if (state == ST_CHECK && !frame_match
                     && slip_count == SLIP_COUNT_W'(WIDTH)) begin
            slip_count  <= '0;
            align_error <= 1'b1;
        end else if (state == ST_SLIP) begin
            slip_count <= slip_count + SLIP_COUNT_W'(1);
        end
    end

    // Data path: capture the word whenever the next cycle is a locked one so valid tracks lock exactly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= (state_next == ST_LOCKED);
            if (state_next == ST_LOCKED) begin
                data_out_q <= bus.data_word;
            end
        end
    end

    assign bus.bitslip     = (state == ST_SLIP) && bus.enable;
    assign bus.locked      = (state == ST_LOCKED);
    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.slip_count  = slip_count;
    assign bus.align_error = align_error;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Directed testbench for adc_frame_aligner with a bit-rotating lane model.
module tb_adc_frame_aligner;

    localparam int               WIDTH   = 12;
    localparam logic [WIDTH-1:0] PATTERN = 12'hFC0;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    adc_frame_aligner_if #(.WIDTH(WIDTH)) bus ();

    adc_frame_aligner #(
        .WIDTH         (WIDTH),
        .FRAME_PATTERN (PATTERN),
        .SLIP_WAIT     (4),
        .LOCK_COUNT    (16),
        .LOSS_COUNT    (4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Free-running word clock.
    always #5 clk = ~clk;

    // Hard stop in case the run gets stuck somewhere.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int n);
        logic [2*WIDTH-1:0] d;
        d = {v, v} << n;
        return d[2*WIDTH-1 -: WIDTH];
    endfunction

    // Drop enable for one cycle, then restart the search with the given frame word.
    task automatic restart_search(input logic [WIDTH-1:0] frame);
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.frame_word = frame;
        bus.enable     = 1'b1;
    endtask

    task automatic test_reset();
        rstn           = 1'b0;
        bus.enable     = 1'b0;
        bus.frame_word = '0;
        bus.data_word  = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.bitslip !== 1'b0) begin fails++; $display("[TB] FAIL reset_bitslip: got %b want 0", bus.bitslip); end
        checks++; if (bus.locked !== 1'b0) begin fails++; $display("[TB] FAIL reset_locked: got %b want 0", bus.locked); end
        checks++; if (bus.data_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", bus.data_valid); end
        checks++; if (bus.data_out !== 12'h000) begin fails++; $display("[TB] FAIL reset_data_out: got %h want 000", bus.data_out); end
        checks++; if (bus.slip_count !== 4'd0) begin fails++; $display("[TB] FAIL reset_slip_count: got %0d want 0", bus.slip_count); end
        checks++; if (bus.align_error !== 1'b0) begin fails++; $display("[TB] FAIL reset_align_error: got %b want 0", bus.align_error); end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (bus.locked !== 1'b0 || bus.bitslip !== 1'b0) begin fails++; $display("[TB] FAIL idle_after_reset: locked=%b bitslip=%b want 0/0", bus.locked, bus.bitslip); end
    endtask

    task automatic test_prealigned();
        logic [WIDTH-1:0] prev_data;
        int slips = 0;
        restart_search(PATTERN);
        bus.data_word = 12'h100;
        prev_data     = bus.data_word;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.bitslip === 1'b1) slips++;
            if (k == 16) begin
                checks++; if (bus.locked !== 1'b0) begin fails++; $display("[TB] FAIL prealigned_early_lock: locked=%b want 0 at cycle 16", bus.locked); end
            end
            if (k == 17) begin
                checks++; if (bus.locked !== 1'b1) begin fails++; $display("[TB] FAIL prealigned_lock: locked=%b want 1 at cycle 17", bus.locked); end
                checks++; if (bus.data_valid !== 1'b1) begin fails++; $display("[TB] FAIL prealigned_valid: data_valid=%b want 1", bus.data_valid); end
            end
            if (k >= 17) begin
                checks++; if (bus.data_out !== prev_data) begin fails++; $display("[TB] FAIL prealigned_data cycle %0d: data_out=%h want %h", k, bus.data_out, prev_data); end
            end
            bus.data_word = 12'h100 + 12'(k);
            prev_data     = bus.data_word;
        end
        checks++; if (slips != 0) begin fails++; $display("[TB] FAIL prealigned_bitslips: got %0d pulses want 0", slips); end
    endtask

    task automatic test_loss_of_lock();
        bus.frame_word = 12'h000;
        repeat (3) @(negedge clk);
        checks++; if (bus.locked !== 1'b1 || bus.data_valid !== 1'b1) begin fails++; $display("[TB] FAIL loss_three_misses: locked=%b valid=%b want 1/1", bus.locked, bus.data_valid); end
        bus.frame_word = PATTERN;
        @(negedge clk);
        checks++; if (bus.locked !== 1'b1) begin fails++; $display("[TB] FAIL loss_forgiven: locked=%b want 1", bus.locked); end
        bus.frame_word = 12'h000;
        repeat (3) @(negedge clk);
        checks++; if (bus.locked !== 1'b1) begin fails++; $display("[TB] FAIL loss_counter_reset: locked=%b want 1 after 3 new misses", bus.locked); end
        @(negedge clk);
        checks++; if (bus.locked !== 1'b0) begin fails++; $display("[TB] FAIL loss_four_misses: locked=%b want 0", bus.locked); end
        checks++; if (bus.data_valid !== 1'b0) begin fails++; $display("[TB] FAIL loss_valid: data_valid=%b want 0", bus.data_valid); end
    endtask

    task automatic test_rotated();
        int offset     = 3;
        int pulses     = 0;
        int last_pulse = -100;
        int min_gap    = 1000;
        int lock_cycle = 0;
        restart_search(rotl(PATTERN, 3));
        for (int k = 1; k <= 80 && lock_cycle == 0; k++) begin
            @(negedge clk);
            if (bus.locked === 1'b1) lock_cycle = k;
            if (bus.bitslip === 1'b1) begin
                pulses++;
                if (k - last_pulse < min_gap) min_gap = k - last_pulse;
                last_pulse     = k;
                offset         = (offset + WIDTH - 1) % WIDTH;
                bus.frame_word = rotl(PATTERN, offset);
            end
        end
        checks++; if (pulses != 3) begin fails++; $display("[TB] FAIL rotated_pulses: got %0d want 3", pulses); end
        checks++; if (min_gap < 6) begin fails++; $display("[TB] FAIL rotated_spacing: min gap %0d want >= 6", min_gap); end
        checks++; if (bus.slip_count !== 4'd3) begin fails++; $display("[TB] FAIL rotated_slip_count: got %0d want 3", bus.slip_count); end
        checks++; if (lock_cycle != 35) begin fails++; $display("[TB] FAIL rotated_lock_cycle: got %0d want 35 (0 = never)", lock_cycle); end
    endtask

    task automatic test_align_error();
        int pulses     = 0;
        int last_pulse = -100;
        int min_gap    = 1000;
        bit done       = 1'b0;
        restart_search(12'h555);
        for (int k = 1; k <= 120 && !done; k++) begin
            @(negedge clk);
            if (bus.bitslip === 1'b1) begin
                pulses++;
                if (k - last_pulse < min_gap) min_gap = k - last_pulse;
                last_pulse = k;
                if (pulses == 12) begin
                    checks++; if (bus.align_error !== 1'b0 || bus.slip_count !== 4'd11) begin fails++; $display("[TB] FAIL error_before_wrap: align_error=%b slip_count=%0d want 0/11", bus.align_error, bus.slip_count); end
                end
                if (pulses == 13) begin
                    done = 1'b1;
                    checks++; if (k != 74) begin fails++; $display("[TB] FAIL error_pulse_cycle: 13th pulse at %0d want 74", k); end
                    checks++; if (bus.slip_count !== 4'd0) begin fails++; $display("[TB] FAIL error_wrap: slip_count=%0d want 0", bus.slip_count); end
                    checks++; if (bus.align_error !== 1'b1) begin fails++; $display("[TB] FAIL error_set: align_error=%b want 1", bus.align_error); end
                    checks++; if (bus.locked !== 1'b0) begin fails++; $display("[TB] FAIL error_locked: locked=%b want 0", bus.locked); end
                end
            end
        end
        checks++; if (!done || min_gap < 6) begin fails++; $display("[TB] FAIL error_search: done=%b min gap %0d want 1/>=6", done, min_gap); end
        bus.frame_word = PATTERN;
        @(negedge clk);
        checks++; if (bus.slip_count !== 4'd1) begin fails++; $display("[TB] FAIL error_resume: slip_count=%0d want 1", bus.slip_count); end
        for (int k = 0; k < 40 && bus.locked !== 1'b1; k++) @(negedge clk);
        checks++; if (bus.locked !== 1'b1) begin fails++; $display("[TB] FAIL error_relock: locked=%b want 1", bus.locked); end
        checks++; if (bus.align_error !== 1'b1) begin fails++; $display("[TB] FAIL error_sticky: align_error=%b want 1", bus.align_error); end
    endtask

    task automatic test_enable_drop();
        bus.data_word = 12'h123;
        @(negedge clk);
        checks++; if (bus.data_out !== 12'h123 || bus.data_valid !== 1'b1) begin fails++; $display("[TB] FAIL drop_setup: data_out=%h valid=%b want 123/1", bus.data_out, bus.data_valid); end
        bus.data_word = 12'hABC;
        bus.enable    = 1'b0;
        @(negedge clk);
        checks++; if (bus.locked !== 1'b0 || bus.data_valid !== 1'b0) begin fails++; $display("[TB] FAIL drop_outputs: locked=%b valid=%b want 0/0", bus.locked, bus.data_valid); end
        checks++; if (bus.align_error !== 1'b0) begin fails++; $display("[TB] FAIL drop_align_error: align_error=%b want 0", bus.align_error); end
        checks++; if (bus.data_out !== 12'h123) begin fails++; $display("[TB] FAIL drop_data_hold: data_out=%h want 123", bus.data_out); end
        restart_search(12'h000);
        repeat (2) @(negedge clk);
        checks++; if (bus.bitslip !== 1'b1) begin fails++; $display("[TB] FAIL drop_slip_setup: bitslip=%b want 1", bus.bitslip); end
        bus.enable = 1'b0;
        @(negedge clk);
        checks++; if (bus.bitslip !== 1'b0 || bus.slip_count !== 4'd0) begin fails++; $display("[TB] FAIL drop_during_slip: bitslip=%b slip_count=%0d want 0/0", bus.bitslip, bus.slip_count); end
    endtask

    task automatic test_reset_during_wait();
        restart_search(12'h555);
        repeat (3) @(negedge clk);
        checks++; if (bus.slip_count !== 4'd1) begin fails++; $display("[TB] FAIL wait_setup: slip_count=%0d want 1", bus.slip_count); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (bus.slip_count !== 4'd0 || bus.bitslip !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_slip: slip_count=%0d bitslip=%b want 0/0", bus.slip_count, bus.bitslip); end
        checks++; if (bus.data_out !== 12'h000 || bus.data_valid !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_data: data_out=%h valid=%b want 000/0", bus.data_out, bus.data_valid); end
        checks++; if (bus.locked !== 1'b0 || bus.align_error !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_status: locked=%b align_error=%b want 0/0", bus.locked, bus.align_error); end
        @(negedge clk);
        rstn           = 1'b1;
        bus.frame_word = PATTERN;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (bus.bitslip !== 1'b0) begin
                checks++; fails++; $display("[TB] FAIL restart_bitslip: pulse at cycle %0d want none", k);
            end
            if (k == 16) begin
                checks++; if (bus.locked !== 1'b0) begin fails++; $display("[TB] FAIL restart_early_lock: locked=%b want 0", bus.locked); end
            end
            if (k == 17) begin
                checks++; if (bus.locked !== 1'b1) begin fails++; $display("[TB] FAIL restart_lock: locked=%b want 1", bus.locked); end
            end
        end
    endtask

    initial begin
        $display("[TB] adc_frame_aligner directed test start");
        test_reset();
        test_prealigned();
        test_loss_of_lock();
        test_rotated();
        test_align_error();
        test_enable_drop();
        test_reset_during_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
